// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with valid/ready handshakes, show-ahead or
// registered read, arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy output, sticky overflow/underflow and sync flush.
module fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ov_q, ov_d;
  logic             uf_q, uf_d;
  logic             push, pop;

  // Pointers wrap explicitly at DEPTH-1 so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ready = (level_q != LW'(DEPTH));
  assign push     = wr_valid & wr_ready & ~flush;
  assign pop      = rd_ready & (level_q != '0) & ~flush;

  // Next-state for pointers, occupancy, threshold flags and sticky errors.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    af_d = (level_d >= LW'(AF_THRESH));
    ae_d = (level_d <= LW'(AE_THRESH));

    // Error setting is suppressed during flush; setting wins over clr_err.
    if (!flush && wr_valid && !wr_ready) ov_d = 1'b1;
    else if (clr_err)                    ov_d = 1'b0;
    else                                 ov_d = ov_q;
    if (!flush && rd_ready && level_q == '0) uf_d = 1'b1;
    else if (clr_err)                        uf_d = 1'b0;
    else                                     uf_d = uf_q;
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ov_q    <= ov_d;
      uf_q    <= uf_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown combinationally; forced to zero while empty.
    always_comb begin
      rd_valid = (level_q != '0);
      rd_data  = rd_valid ? mem_q[rptr_q] : '0;
    end
  end else begin : g_regrd
    logic             rdv_q, rdv_d;
    logic [WIDTH-1:0] rdd_q, rdd_d;

    // Popped word appears one cycle after the pop for exactly one cycle.
    always_comb begin
      rdv_d = pop;
      rdd_d = pop ? mem_q[rptr_q] : rdd_q;
    end

    // Registered read-port state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdv_q <= 1'b0;
        rdd_q <= '0;
      end else begin
        rdv_q <= rdv_d;
        rdd_q <= rdd_d;
      end
    end

    assign rd_valid = rdv_q;
    assign rd_data  = rdd_q;
  end

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ov_q;
  assign underflow    = uf_q;

endmodule
